ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter AW, default 8: RAM word-address width; RAM depth is 2^AW 32-bit words.
REQ-002 Parameter MAX_WAIT, default 3: consecutive denied cycles after which port A gets priority over port B.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 a_req_i  input  1  core port request.
REQ-006 a_we_i  input  1  core port write.
REQ-007 a_addr_i  input  14  core word address.
REQ-008 a_wdata_i  input  32  core write data.
REQ-009 a_wmask_i  input  32  core bit write mask.
REQ-010 a_gnt_o  output  1  core request accepted this cycle.
REQ-011 a_rvalid_o  output  1  core response valid.
REQ-012 a_rdata_o  output  32  core read data.
REQ-013 a_rerror_o  output  2  core response error.
REQ-014 b_req_i  input  1  loader port request.
REQ-015 b_we_i  input  1  loader port write; the loader always writes the full word.
REQ-016 b_addr_i  input  14  loader word address.
REQ-017 b_wdata_i  input  32  loader write data.
REQ-018 b_gnt_o  output  1  loader request accepted this cycle.
REQ-019 b_rvalid_o  output  1  loader response valid.
REQ-020 b_rdata_o  output  32  loader read data.
REQ-021 b_rerror_o  output  2  loader response error.
REQ-022 ram_en_o  output  1  RAM enable.
REQ-023 ram_we_o  output  4  RAM byte write enables.
REQ-024 ram_a_o  output  AW  RAM address.
REQ-025 ram_di_o  output  32  RAM write data.
REQ-026 ram_do_i  input  32  RAM read data, valid the cycle after an enabled read.

Function
REQ-027 Arbitration is combinational in the request cycle, and at most one grant is asserted per cycle.
REQ-028 Priority:
- Port B wins when both ports request.
- Exception: port A wins when wait_q == MAX_WAIT.
REQ-029 wait_q (counter, saturating at MAX_WAIT):
- Increments when a_req_i=1 and a_gnt_o=0.
- Clears when a_gnt_o=1 or a_req_i=0.
REQ-030 A lone requester is granted in the same cycle it requests.
REQ-031 Granted in-range request drives ram_en_o=1, ram_a_o=addr[AW-1:0], and ram_di_o from the winning port.
REQ-032 In-range means addr[13:AW]==0.
REQ-033 Port A byte enable: ram_we_o[i] = a_we_i & (a_wmask_i[8i+7:8i] != 0).
REQ-034 Port B byte enable: ram_we_o = {4{b_we_i}}.
REQ-035 A granted out-of-range request:
- Is still granted.
- Drives ram_en_o=0 and ram_we_o=0.
- Produces a response with rerror=2'b01 and rdata=0.
REQ-036 With no grant, ram_en_o=0 and ram_we_o=0; ram_a_o and ram_di_o are don't-care.
REQ-037 Response pipeline registers: owner, was_write, and was_err, captured at grant.
REQ-038 Every grant produces exactly one rvalid on the granted port, one cycle later (latency 1), for reads and writes alike.
REQ-039 Response data:
- Reads: rdata = ram_do_i during the rvalid cycle.
- Writes and errors: rdata = 0.
- Non-owner port: rdata = 0.
REQ-040 rerror=2'b00 for in-range responses.
REQ-041 Back-to-back grants are allowed every cycle, to either port, with no bubble.
REQ-042 Requests must not be held by the requester after grant; a request still high the next cycle is a new request.

Reset
REQ-043 While rst_ni=0, regardless of clock, the following are 0 and all pending responses are discarded:
- wait_q.
- All response pipeline registers.
- a_rvalid_o, b_rvalid_o.
- a_rerror_o, b_rerror_o.
- rdata outputs.
REQ-044 While rst_ni=0, the combinational grant and RAM outputs are held at 0.
REQ-045 Arbitration resumes on the first rising edge after rst_ni deasserts.

Verification
REQ-046 a_req_i=1 only, read addr 5, RAM holds 0xDEADBEEF:
- Same cycle: a_gnt_o=1, ram_a_o=5.
- Next cycle: a_rvalid_o=1, a_rdata_o=0xDEADBEEF, a_rerror_o=0.
REQ-047 Both ports request continuously, MAX_WAIT=3:
- Cycles 0-2: B granted.
- Cycle 3: A granted.
- Cycles 4-6: B granted.
- Pattern repeats with no idle cycle.
REQ-048 Port A write with wmask=0x00FF0000, wdata=0x11223344: ram_we_o=4'b0100, and a_rvalid_o=1 with a_rdata_o=0 the next cycle.
REQ-049 Port B write to addr 0x100 with AW=8: b_gnt_o=1, ram_en_o=0, and the next cycle b_rvalid_o=1 with b_rerror_o=2'b01.
REQ-050 rst_ni asserted low mid-cycle after a grant: a_rvalid_o, b_rvalid_o, and wait_q go to 0 immediately, and no response appears after rst_ni deasserts.
REQ-051 Alternate A-read/B-read every cycle: each rvalid appears only on its own port, and the rdata of the other port stays 0.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Request/response and RAM-side signals between two requesters (core A, loader B) and the RAM arbiter.
interface ram_port_arbiter_if #(
    parameter int AW = 8
);
    logic          a_req_i;
    logic          a_we_i;
    logic [13:0]   a_addr_i;
    logic [31:0]   a_wdata_i;
    logic [31:0]   a_wmask_i;
    logic          a_gnt_o;
    logic          a_rvalid_o;
    logic [31:0]   a_rdata_o;
    logic [1:0]    a_rerror_o;

    logic          b_req_i;
    logic          b_we_i;
    logic [13:0]   b_addr_i;
    logic [31:0]   b_wdata_i;
    logic          b_gnt_o;
    logic          b_rvalid_o;
    logic [31:0]   b_rdata_o;
    logic [1:0]    b_rerror_o;

    logic          ram_en_o;
    logic [3:0]    ram_we_o;
    logic [AW-1:0] ram_a_o;
    logic [31:0]   ram_di_o;
    logic [31:0]   ram_do_i;

    modport master (
        output a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
        output b_req_i, b_we_i, b_addr_i, b_wdata_i,
        output ram_do_i,
        input  a_gnt_o, a_rvalid_o, a_rdata_o, a_rerror_o,
        input  b_gnt_o, b_rvalid_o, b_rdata_o, b_rerror_o,
        input  ram_en_o, ram_we_o, ram_a_o, ram_di_o
    );

    modport slave (
        input  a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
        input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
        input  ram_do_i,
        output a_gnt_o, a_rvalid_o, a_rdata_o, a_rerror_o,
        output b_gnt_o, b_rvalid_o, b_rdata_o, b_rerror_o,
        output ram_en_o, ram_we_o, ram_a_o, ram_di_o
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port single-RAM arbiter: B wins ties unless A has waited MAX_WAIT cycles; grant is same-cycle.
// Response latency 1 cycle for every grant; no backpressure, a denied requester simply re-requests.
module ram_port_arbiter #(
    parameter int AW       = 8,
    parameter int MAX_WAIT = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    ram_port_arbiter_if.slave bus
);
    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_q;
    logic          a_in_range, b_in_range;
    logic          a_gnt, b_gnt;
    logic          gnt_wr, gnt_err;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_di;

    logic          rsp_vld_q, rsp_own_q, rsp_wr_q, rsp_err_q;
    logic [31:0]   rsp_data;

    assign a_in_range = (bus.a_addr_i >> AW) == 14'd0;
    assign b_in_range = (bus.b_addr_i >> AW) == 14'd0;

    always_comb begin
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        gnt_wr  = 1'b0;
        gnt_err = 1'b0;
        ram_en  = 1'b0;
        ram_we  = 4'b0000;
        ram_a   = '0;
        ram_di  = '0;
        // Grants are forced off while reset is held, independent of the clock.
        if (rst_ni) begin
            if (bus.a_req_i && (!bus.b_req_i || wait_q == WW'(MAX_WAIT))) begin
                a_gnt = 1'b1;
            end else if (bus.b_req_i) begin
                b_gnt = 1'b1;
            end
        end
        if (a_gnt) begin
            gnt_wr  = bus.a_we_i;
            gnt_err = !a_in_range;
            ram_en  = a_in_range;
            ram_a   = bus.a_addr_i[AW-1:0];
            ram_di  = bus.a_wdata_i;
            for (int i = 0; i < 4; i++) begin
                ram_we[i] = a_in_range && bus.a_we_i && (bus.a_wmask_i[8*i +: 8] != 8'd0);
            end
        end else if (b_gnt) begin
            gnt_wr  = bus.b_we_i;
            gnt_err = !b_in_range;
            ram_en  = b_in_range;
            ram_a   = bus.b_addr_i[AW-1:0];
            ram_di  = bus.b_wdata_i;
            ram_we  = {4{b_in_range && bus.b_we_i}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else if (bus.a_req_i && !a_gnt) begin
            if (wait_q != WW'(MAX_WAIT)) begin
                wait_q <= wait_q + WW'(1);
            end
        end else begin
            wait_q <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld_q <= 1'b0;
            rsp_own_q <= 1'b0;
            rsp_wr_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_vld_q <= a_gnt || b_gnt;
            rsp_own_q <= b_gnt;
            rsp_wr_q  <= gnt_wr;
            rsp_err_q <= gnt_err;
        end
    end

    // Only in-range reads return RAM data; writes and errors answer with zero.
    assign rsp_data = (rsp_wr_q || rsp_err_q) ? 32'd0 : bus.ram_do_i;

    assign bus.a_gnt_o    = a_gnt;
    assign bus.b_gnt_o    = b_gnt;
    assign bus.ram_en_o   = ram_en;
    assign bus.ram_we_o   = ram_we;
    assign bus.ram_a_o    = ram_a;
    assign bus.ram_di_o   = ram_di;

    assign bus.a_rvalid_o = rsp_vld_q && !rsp_own_q;
    assign bus.b_rvalid_o = rsp_vld_q && rsp_own_q;
    assign bus.a_rdata_o  = bus.a_rvalid_o ? rsp_data : 32'd0;
    assign bus.b_rdata_o  = bus.b_rvalid_o ? rsp_data : 32'd0;
    assign bus.a_rerror_o = (bus.a_rvalid_o && rsp_err_q) ? 2'b01 : 2'b00;
    assign bus.b_rerror_o = (bus.b_rvalid_o && rsp_err_q) ? 2'b01 : 2'b00;
endmodule
